// File: rtl/sdram_arbiter_n.sv
// N-client SDRAM port arbiter: urgent-first then round-robin grants, gated by a
// per-client enable mask, with burst-limited ownership of the controller port.
module sdram_arbiter_n #(
  parameter int N_CLIENTS = 4,
  parameter int ADDR_W    = 22,
  parameter int DATA_W    = 128,
  parameter int MAX_BURST = 16,
  localparam int BE_W     = DATA_W / 8,
  localparam int ID_W     = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CLIENTS-1:0]      cl_en,
  input  logic [N_CLIENTS-1:0]      cl_urgent,
  input  logic [N_CLIENTS-1:0]      cl_rd,
  input  logic [N_CLIENTS-1:0]      cl_wr,
  input  logic [N_CLIENTS*ADDR_W-1:0] cl_addr,
  input  logic [N_CLIENTS*DATA_W-1:0] cl_wrdata,
  input  logic [N_CLIENTS*BE_W-1:0] cl_be,
  output logic [N_CLIENTS-1:0]      cl_wait,
  output logic [N_CLIENTS-1:0]      cl_ac,
  output logic [DATA_W-1:0]         cl_rddata,
  output logic [ADDR_W-1:0]         ar_addr,
  output logic [BE_W-1:0]           ar_be,
  output logic                      ar_read,
  output logic                      ar_write,
  output logic [DATA_W-1:0]         ar_wrdata,
  input  logic                      ar_ac,
  input  logic [DATA_W-1:0]         ar_rddata,
  output logic                      grant_valid,
  output logic [ID_W-1:0]           grant_id,
  output logic                      proto_err
);

  // Handshake: a client holds rd/wr until cl_ac; each ar_ac is one beat of the
  // owner and is routed only to it. ar_ac seen while idle belongs to nobody.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  logic [0:0]           state;
  logic [ID_W-1:0]      rr_ptr;
  logic [CNT_W-1:0]     beat_cnt;
  logic [N_CLIENTS-1:0] eligible;
  logic                 any_elig;
  logic                 found_urg;
  logic                 found_rr;
  logic [ID_W-1:0]      urg_win;
  logic [ID_W-1:0]      rr_win;
  logic [ID_W-1:0]      winner;
  logic [ID_W-1:0]      next_ptr;
  int                   idx;

  logic               own_rd;
  logic               own_wr;
  logic [ADDR_W-1:0]  own_addr;
  logic [DATA_W-1:0]  own_wrdata;
  logic [BE_W-1:0]    own_be;

  always_comb begin
    eligible  = cl_en & (cl_rd | cl_wr);
    any_elig  = |eligible;
    found_urg = 1'b0;
    found_rr  = 1'b0;
    urg_win   = '0;
    rr_win    = '0;
    idx       = 0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (!found_urg && eligible[i] && cl_urgent[i]) begin
        found_urg = 1'b1;
        urg_win   = ID_W'(i);
      end
    end
    // Upward search starting at rr_ptr, wrapping at N_CLIENTS.
    for (int k = 0; k < N_CLIENTS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_CLIENTS) idx = idx - N_CLIENTS;
      if (!found_rr && eligible[idx[ID_W-1:0]]) begin
        found_rr = 1'b1;
        rr_win   = idx[ID_W-1:0];
      end
    end
    winner   = found_urg ? urg_win : rr_win;
    next_ptr = (int'(winner) == N_CLIENTS - 1) ? '0 : winner + 1'b1;
  end

  always_comb begin
    own_rd     = cl_rd[grant_id];
    own_wr     = cl_wr[grant_id];
    own_addr   = cl_addr[int'(grant_id)*ADDR_W +: ADDR_W];
    own_wrdata = cl_wrdata[int'(grant_id)*DATA_W +: DATA_W];
    own_be     = cl_be[int'(grant_id)*BE_W +: BE_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      grant_id  <= '0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_elig) begin
            state    <= ST_OWN;
            grant_id <= winner;
            rr_ptr   <= next_ptr;
            beat_cnt <= '0;
          end
        end
        default: begin
          if (own_rd && own_wr) proto_err <= 1'b1;
          // Enable-mask changes never cut a grant short; only these two exits.
          if (ar_ac) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) state <= ST_IDLE;
          end else if (!own_rd && !own_wr) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // grant_valid doubles as the visible FSM state (1 = OWN).
  assign grant_valid = (state == ST_OWN);
  assign cl_rddata   = ar_rddata;

  always_comb begin
    ar_addr   = '0;
    ar_wrdata = '0;
    ar_be     = '1;
    ar_read   = 1'b0;
    ar_write  = 1'b0;
    cl_wait   = '1;
    cl_ac     = '0;
    if (state == ST_OWN) begin
      ar_addr            = own_addr;
      ar_wrdata          = own_wrdata;
      ar_be              = own_be;
      ar_write           = own_wr;
      ar_read            = own_rd & ~own_wr;
      cl_wait[grant_id]  = 1'b0;
      cl_ac[grant_id]    = ar_ac;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter_n.sv
// Bench for sdram_arbiter_n: directed scenarios plus randomized traffic checked
// against a transaction-level ownership model.
module tb_sdram_arbiter_n;
  localparam int N  = 4;
  localparam int AW = 22;
  localparam int DW = 128;
  localparam int BW = DW / 8;
  localparam int MB = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  cl_en, cl_urgent, cl_rd, cl_wr;
  logic [N*AW-1:0] cl_addr;
  logic [N*DW-1:0] cl_wrdata;
  logic [N*BW-1:0] cl_be;
  logic [N-1:0]  cl_wait, cl_ac;
  logic [DW-1:0] cl_rddata;
  logic [AW-1:0] ar_addr;
  logic [BW-1:0] ar_be;
  logic          ar_read, ar_write;
  logic [DW-1:0] ar_wrdata;
  logic          ar_ac;
  logic [DW-1:0] ar_rddata;
  logic          grant_valid;
  logic [1:0]    grant_id;
  logic          proto_err;

  int total = 0;
  int bad = 0;

  sdram_arbiter_n #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .cl_en(cl_en), .cl_urgent(cl_urgent),
    .cl_rd(cl_rd), .cl_wr(cl_wr), .cl_addr(cl_addr), .cl_wrdata(cl_wrdata),
    .cl_be(cl_be), .cl_wait(cl_wait), .cl_ac(cl_ac), .cl_rddata(cl_rddata),
    .ar_addr(ar_addr), .ar_be(ar_be), .ar_read(ar_read), .ar_write(ar_write),
    .ar_wrdata(ar_wrdata), .ar_ac(ar_ac), .ar_rddata(ar_rddata),
    .grant_valid(grant_valid), .grant_id(grant_id), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_payload();
    for (int i = 0; i < N; i++) begin
      cl_addr[i*AW +: AW]   = AW'($urandom);
      cl_wrdata[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
      cl_be[i*BW +: BW]     = BW'($urandom);
    end
    ar_rddata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic clear_inputs();
    cl_en = '0; cl_urgent = '0; cl_rd = '0; cl_wr = '0; ar_ac = 1'b0;
    fill_payload();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    cl_en = '1; cl_rd = 4'b1111; ar_ac = 1'b1;
    tick();
    tick();
    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL reset_gv got=%0b exp=0", grant_valid); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d exp=0", grant_id); end
    total++; if (ar_read !== 1'b0 || ar_write !== 1'b0) begin bad++; $display("FAIL reset_strobes got=%0b%0b exp=00", ar_read, ar_write); end
    total++; if (ar_addr !== '0 || ar_wrdata !== '0) begin bad++; $display("FAIL reset_addr_data got=%h exp=0", ar_addr); end
    total++; if (ar_be !== 16'hFFFF) begin bad++; $display("FAIL reset_be got=%h exp=ffff", ar_be); end
    total++; if (cl_wait !== 4'hF || cl_ac !== 4'h0) begin bad++; $display("FAIL reset_wait_ac got=%b/%b exp=1111/0000", cl_wait, cl_ac); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL reset_proto got=%0b exp=0", proto_err); end
    cl_rd = '0;
    reset = 1'b0;
    tick();
    #1;
    total++; if (cl_ac !== 4'h0) begin bad++; $display("FAIL idle_ac_routed got=%b exp=0000", cl_ac); end
    ar_ac = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    cl_en = '1; cl_rd = 4'b0100;
    #1;
    total++; if (cl_wait !== 4'hF) begin bad++; $display("FAIL single_pre_wait got=%b exp=1111", cl_wait); end
    tick();
    total++; if (ar_read !== 1'b1 || ar_write !== 1'b0) begin bad++; $display("FAIL single_read got=%0b%0b exp=10", ar_read, ar_write); end
    total++; if (ar_addr !== cl_addr[2*AW +: AW]) begin bad++; $display("FAIL single_addr got=%h exp=%h", ar_addr, cl_addr[2*AW +: AW]); end
    total++; if (cl_wait !== 4'b1011) begin bad++; $display("FAIL single_wait got=%b exp=1011", cl_wait); end
    total++; if (grant_valid !== 1'b1 || grant_id !== 2'd2) begin bad++; $display("FAIL single_grant got=%0b/%0d exp=1/2", grant_valid, grant_id); end
    tick();
    total++; if (cl_ac !== 4'b0000) begin bad++; $display("FAIL single_noack got=%b exp=0000", cl_ac); end
    ar_ac = 1'b1;
    #1;
    total++; if (cl_ac !== 4'b0100) begin bad++; $display("FAIL single_ack got=%b exp=0100", cl_ac); end
    tick();
    ar_ac = 1'b0; cl_rd = '0;
    #1;
    total++; if (cl_ac !== 4'b0000 || grant_valid !== 1'b1) begin bad++; $display("FAIL single_after_ack got=%b/%0b exp=0000/1", cl_ac, grant_valid); end
    tick();
    total++; if (grant_valid !== 1'b0 || cl_wait !== 4'hF) begin bad++; $display("FAIL single_release got=%0b/%b exp=0/1111", grant_valid, cl_wait); end
  endtask

  task automatic test_round_robin();
    int order[6] = '{0, 1, 3, 0, 1, 3};
    do_reset();
    cl_en = '1; cl_rd = 4'b1011; ar_ac = 1'b1;
    #1;
    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL rr_start_idle got=%0b exp=0", grant_valid); end
    for (int g = 0; g < 6; g++) begin
      tick();
      total++; if (grant_valid !== 1'b1 || grant_id !== 2'(order[g]) || cl_ac !== 4'(1 << order[g]))
        begin bad++; $display("FAIL rr_beat1 g=%0d got=%0b/%0d/%b exp=1/%0d", g, grant_valid, grant_id, cl_ac, order[g]); end
      tick();
      total++; if (grant_valid !== 1'b1 || grant_id !== 2'(order[g]))
        begin bad++; $display("FAIL rr_beat2 g=%0d got=%0b/%0d exp=1/%0d", g, grant_valid, grant_id, order[g]); end
      tick();
      total++; if (grant_valid !== 1'b0 || cl_ac !== 4'h0)
        begin bad++; $display("FAIL rr_bubble g=%0d got=%0b/%b exp=0/0000", g, grant_valid, cl_ac); end
    end
    clear_inputs();
  endtask

  task automatic test_urgent();
    do_reset();
    cl_en = '1; cl_rd = 4'b0001;
    tick();
    cl_rd = 4'b1010; cl_urgent = 4'b1000;
    tick();
    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL urg_idle got=%0b exp=0", grant_valid); end
    tick();
    total++; if (grant_valid !== 1'b1 || grant_id !== 2'd3) begin bad++; $display("FAIL urg_first got=%0b/%0d exp=1/3", grant_valid, grant_id); end
    cl_rd = 4'b0010;
    tick();
    tick();
    total++; if (grant_valid !== 1'b1 || grant_id !== 2'd1) begin bad++; $display("FAIL urg_second got=%0b/%0d exp=1/1", grant_valid, grant_id); end
    clear_inputs();
  endtask

  task automatic test_en_drop();
    do_reset();
    cl_en = '1; cl_rd = 4'b0001;
    tick();
    cl_en = 4'b1110;
    #1;
    total++; if (grant_valid !== 1'b1 || ar_read !== 1'b1) begin bad++; $display("FAIL endrop_hold got=%0b/%0b exp=1/1", grant_valid, ar_read); end
    tick();
    total++; if (grant_valid !== 1'b1 || ar_read !== 1'b1) begin bad++; $display("FAIL endrop_hold2 got=%0b/%0b exp=1/1", grant_valid, ar_read); end
    ar_ac = 1'b1;
    tick();
    total++; if (grant_valid !== 1'b1 || cl_ac !== 4'b0001) begin bad++; $display("FAIL endrop_ack2 got=%0b/%b exp=1/0001", grant_valid, cl_ac); end
    tick();
    ar_ac = 1'b0;
    #1;
    total++; if (grant_valid !== 1'b0 || ar_read !== 1'b0) begin bad++; $display("FAIL endrop_release got=%0b/%0b exp=0/0", grant_valid, ar_read); end
    tick();
    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL endrop_no_regrant got=%0b exp=0", grant_valid); end
    cl_rd = 4'b0011;
    tick();
    total++; if (grant_valid !== 1'b1 || grant_id !== 2'd1) begin bad++; $display("FAIL endrop_other got=%0b/%0d exp=1/1", grant_valid, grant_id); end
    clear_inputs();
  endtask

  task automatic test_proto();
    do_reset();
    cl_en = '1; cl_rd = 4'b0001; cl_wr = 4'b0001;
    cl_be[0 +: BW] = 16'h00F0;
    tick();
    total++; if (ar_write !== 1'b1 || ar_read !== 1'b0) begin bad++; $display("FAIL proto_strobes got=%0b%0b exp=01", ar_read, ar_write); end
    total++; if (ar_be !== 16'h00F0) begin bad++; $display("FAIL proto_be got=%h exp=00f0", ar_be); end
    tick();
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_set got=%0b exp=1", proto_err); end
    cl_rd = '0; cl_wr = '0;
    tick();
    tick();
    total++; if (proto_err !== 1'b1 || grant_valid !== 1'b0) begin bad++; $display("FAIL proto_sticky got=%0b/%0b exp=1/0", proto_err, grant_valid); end
  endtask

  task automatic test_reset_mid();
    cl_en = '1; cl_rd = '0; cl_wr = 4'b0010;
    tick();
    total++; if (ar_write !== 1'b1 || grant_id !== 2'd1) begin bad++; $display("FAIL rmid_own got=%0b/%0d exp=1/1", ar_write, grant_id); end
    reset = 1'b1; cl_wr = 4'b0110;
    tick();
    total++; if (ar_write !== 1'b0 || ar_read !== 1'b0 || ar_addr !== '0 || ar_wrdata !== '0 || ar_be !== 16'hFFFF)
      begin bad++; $display("FAIL rmid_ar got=%0b%0b addr=%h be=%h exp=00/0/ffff", ar_read, ar_write, ar_addr, ar_be); end
    total++; if (cl_wait !== 4'hF || grant_valid !== 1'b0 || proto_err !== 1'b0)
      begin bad++; $display("FAIL rmid_state got=%b/%0b/%0b exp=1111/0/0", cl_wait, grant_valid, proto_err); end
    reset = 1'b0;
    tick();
    total++; if (grant_valid !== 1'b1 || grant_id !== 2'd1) begin bad++; $display("FAIL rmid_regrant got=%0b/%0d exp=1/1", grant_valid, grant_id); end
    clear_inputs();
  endtask

  task automatic test_random();
    int own, ptr, beats, w, c;
    bit err;
    logic [N-1:0] elig, e_wait, e_ac;
    logic e_rd, e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [BW-1:0] e_be;
    do_reset();
    own = -1; ptr = 0; beats = 0; err = 1'b0;
    repeat (3000) begin
      cl_en     = 4'($urandom) | 4'($urandom);
      cl_rd     = 4'($urandom) & 4'($urandom);
      cl_wr     = 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 31) != 0) cl_wr = cl_wr & ~cl_rd;
      cl_urgent = 4'($urandom) & 4'($urandom) & 4'($urandom);
      ar_ac     = ($urandom_range(0, 1) == 1);
      fill_payload();
      #1;
      if (own >= 0) begin
        e_wr = cl_wr[own]; e_rd = cl_rd[own] & ~cl_wr[own];
        e_addr = cl_addr[own*AW +: AW]; e_data = cl_wrdata[own*DW +: DW]; e_be = cl_be[own*BW +: BW];
        e_wait = ~(4'(1 << own)); e_ac = ar_ac ? 4'(1 << own) : 4'h0;
      end else begin
        e_wr = 1'b0; e_rd = 1'b0; e_addr = '0; e_data = '0; e_be = '1; e_wait = 4'hF; e_ac = 4'h0;
      end
      total++; if (grant_valid !== (own >= 0)) begin bad++; $display("FAIL rnd_gv got=%0b exp=%0b", grant_valid, own >= 0); end
      if (own >= 0) begin
        total++; if (grant_id !== 2'(own)) begin bad++; $display("FAIL rnd_id got=%0d exp=%0d", grant_id, own); end
      end
      total++; if (ar_read !== e_rd || ar_write !== e_wr) begin bad++; $display("FAIL rnd_strobes got=%0b%0b exp=%0b%0b", ar_read, ar_write, e_rd, e_wr); end
      total++; if (ar_addr !== e_addr) begin bad++; $display("FAIL rnd_addr got=%h exp=%h", ar_addr, e_addr); end
      total++; if (ar_wrdata !== e_data) begin bad++; $display("FAIL rnd_wrdata got=%h exp=%h", ar_wrdata, e_data); end
      total++; if (ar_be !== e_be) begin bad++; $display("FAIL rnd_be got=%h exp=%h", ar_be, e_be); end
      total++; if (cl_wait !== e_wait || cl_ac !== e_ac) begin bad++; $display("FAIL rnd_wait_ac got=%b/%b exp=%b/%b", cl_wait, cl_ac, e_wait, e_ac); end
      total++; if (proto_err !== err) begin bad++; $display("FAIL rnd_proto got=%0b exp=%0b", proto_err, err); end
      total++; if (cl_rddata !== ar_rddata) begin bad++; $display("FAIL rnd_rddata got=%h exp=%h", cl_rddata, ar_rddata); end
      // Model of ownership: who holds the port after this edge.
      if (own < 0) begin
        elig = cl_en & (cl_rd | cl_wr);
        w = -1;
        for (int i = 0; i < N; i++) if (w < 0 && elig[i] && cl_urgent[i]) w = i;
        for (int k = 0; k < N; k++) begin
          c = (ptr + k) % N;
          if (w < 0 && elig[c]) w = c;
        end
        if (w >= 0) begin own = w; ptr = (w + 1) % N; beats = 0; end
      end else begin
        if (cl_rd[own] && cl_wr[own]) err = 1'b1;
        if (ar_ac) begin
          beats++;
          if (beats == MB) own = -1;
        end else if (!cl_rd[own] && !cl_wr[own]) begin
          own = -1;
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_urgent();
    test_en_drop();
    test_proto();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
